// File: rtl/stepdir_if.sv
// Bundles the step/dir decoder's control inputs and result registers.
// The master side drives the inputs; the slave side is the decoder itself.
interface stepdir_if;
    logic               enable;
    logic               step_in;
    logic               dir_in;
    logic               position_clear;
    logic               error_clear;
    logic signed [31:0] position;
    logic        [31:0] period;
    logic               direction;
    logic               moving;
    logic               dir_error;

    modport master (
        output enable, step_in, dir_in, position_clear, error_clear,
        input  position, period, direction, moving, dir_error
    );

    modport slave (
        input  enable, step_in, dir_in, position_clear, error_clear,
        output position, period, direction, moving, dir_error
    );
endinterface

// File: rtl/stepdir_decoder.sv
// Step/dir receiver: synchronises and glitch-filters step/dir, accumulates a signed
// position, measures the step period, tracks motion and flags dir setup violations.
module stepdir_decoder #(
    parameter int FILTER_LEN = 2,
    parameter int DIR_SETUP  = 1,
    parameter int TIMEOUT    = 5000000
) (
    input  logic     clk,
    input  logic     rst_n,
    stepdir_if.slave bus
);

    localparam int              FCW    = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int              SW     = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [SW-1:0]   SETUP  = SW'(DIR_SETUP);
    localparam logic [31:0]     TMO    = 32'(TIMEOUT);
    localparam logic [31:0]     TMO_M1 = 32'(TIMEOUT - 1);

    // Bit 1 carries step, bit 0 carries dir; both see identical delay so setup is preserved.
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    logic [1:0] w_filt;
    logic       w_dir_upd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {bus.step_in, bus.dir_in};
            r_s2 <= r_s1;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign w_filt    = r_s2;
            assign w_dir_upd = r_s1[0] ^ r_s2[0];
        end else begin : g_filter
            localparam logic [FCW-1:0] LAST = FCW'(FILTER_LEN - 1);
            logic [1:0] w_take;

            for (genvar g = 0; g < 2; g++) begin : g_bit
                logic [FCW-1:0] r_fcnt;
                logic           r_filt;
                logic           w_diff;

                assign w_diff    = r_s2[g] ^ r_filt;
                assign w_take[g] = w_diff && (r_fcnt == LAST);
                assign w_filt[g] = r_filt;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_fcnt <= '0;
                        r_filt <= 1'b0;
                    end else if (!w_diff) begin
                        r_fcnt <= '0;
                    end else if (w_take[g]) begin
                        r_fcnt <= '0;
                        r_filt <= r_s2[g];
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
            end

            // The dir stability count restarts on the same edge that the filtered dir flips.
            assign w_dir_upd = w_take[0];
        end
    endgenerate

    logic          w_step_filt;
    logic          w_dir_filt;
    logic          w_edge;
    logic          w_count;
    logic          w_setup_bad;
    logic          r_step_prev;
    logic [SW-1:0] r_dir_stab;

    assign w_step_filt = w_filt[1];
    assign w_dir_filt  = w_filt[0];
    assign w_edge      = w_step_filt & ~r_step_prev;
    assign w_count     = w_edge & bus.enable;
    assign w_setup_bad = (r_dir_stab < SETUP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_prev <= 1'b0;
            r_dir_stab  <= '0;
        end else begin
            r_step_prev <= w_step_filt;
            if (w_dir_upd) begin
                r_dir_stab <= '0;
            end else if (r_dir_stab < SETUP) begin
                r_dir_stab <= r_dir_stab + 1'b1;
            end
        end
    end

    logic signed [31:0] r_position;
    logic signed [31:0] w_pos_base;
    logic signed [31:0] w_pos_next;

    // A clear coinciding with a counted edge lands on +/-1, not 0.
    always_comb begin
        w_pos_base = bus.position_clear ? 32'sd0 : r_position;
        w_pos_next = w_pos_base;
        if (w_count) begin
            w_pos_next = w_dir_filt ? (w_pos_base + 32'sd1) : (w_pos_base - 32'sd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_position <= 32'sd0;
        end else begin
            r_position <= w_pos_next;
        end
    end

    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic        r_moving;

    // r_cnt parked at TMO means "no valid reference edge", so the next edge only restarts timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= TMO;
            r_period <= '0;
            r_moving <= 1'b0;
        end else if (!bus.enable) begin
            r_cnt    <= TMO;
            r_period <= '0;
            r_moving <= 1'b0;
        end else if (w_edge) begin
            if (r_cnt < TMO) begin
                r_period <= r_cnt;
                r_moving <= 1'b1;
            end
            r_cnt <= 32'd1;
        end else if (r_cnt < TMO) begin
            r_cnt <= r_cnt + 32'd1;
            if (r_cnt == TMO_M1) begin
                r_moving <= 1'b0;
                r_period <= '0;
            end
        end
    end

    logic r_direction;
    logic r_dir_error;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_direction <= 1'b0;
            r_dir_error <= 1'b0;
        end else begin
            if (w_count) begin
                r_direction <= w_dir_filt;
            end
            if (w_count && w_setup_bad) begin
                r_dir_error <= 1'b1;
            end else if (bus.error_clear) begin
                r_dir_error <= 1'b0;
            end
        end
    end

    assign bus.position  = r_position;
    assign bus.period    = r_period;
    assign bus.direction = r_direction;
    assign bus.moving    = r_moving;
    assign bus.dir_error = r_dir_error;

endmodule

// File: tb/tb_stepdir_decoder.sv
// Bench for stepdir_decoder: vector table of pulse trains plus hand-written corner
// sequences; position updates are checked against an expected queue as they appear.
module tb_stepdir_decoder;

    logic clk;
    logic rst_n;

    stepdir_if bus();

    stepdir_decoder #(
        .FILTER_LEN(2),
        .DIR_SETUP (4),
        .TIMEOUT   (100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tb_pos;
    logic [31:0] mon_last;
    bit          mon_on = 1'b0;

    typedef struct {
        logic        dir;
        logic        en;
        int          n;
        int          hi;
        int          lo;
        logic [31:0] exp_pos;
        logic [31:0] exp_period;
        logic        exp_mov;
        logic        exp_dirn;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Every change of position while monitoring must match the next queued value.
    always @(negedge clk) begin
        if (mon_on && (bus.position !== mon_last)) begin
            if (exp_q.size() == 0) begin
                check("pos_unexpected", bus.position, mon_last);
            end else begin
                check("pos_sb", bus.position, exp_q.pop_front());
            end
        end
        mon_last = bus.position;
    end

    task automatic pulse(input int hi, input int lo);
        bus.step_in = 1'b1;
        repeat (hi) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic push_step(input logic dir);
        tb_pos = dir ? (tb_pos + 32'd1) : (tb_pos - 32'd1);
        exp_q.push_back(tb_pos);
    endtask

    task automatic wait_pos(input logic [31:0] v, input string nm);
        int k;
        k = 0;
        while ((bus.position !== v) && (k < 40)) begin
            @(negedge clk);
            k++;
        end
        check(nm, bus.position, v);
    endtask

    task automatic clear_pos(input string nm);
        mon_on = 1'b0;
        bus.position_clear = 1'b1;
        @(negedge clk);
        bus.position_clear = 1'b0;
        check(nm, bus.position, 32'd0);
        tb_pos = 32'd0;
        @(negedge clk);
        mon_on = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 10, 4, 4,  32'd10, 32'd8,  1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 3,  5, 7,  32'd13, 32'd12, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 3,  4, 4,  32'd10, 32'd8,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 5,  4, 4,  32'd10, 32'd0,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 4,  6, 10, 32'd14, 32'd16, 1'b1, 1'b1};

        rst_n              = 1'b0;
        bus.enable         = 1'b1;
        bus.step_in        = 1'b0;
        bus.dir_in         = 1'b1;
        bus.position_clear = 1'b0;
        bus.error_clear    = 1'b0;
        tb_pos             = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_position",  bus.position,  32'd0);
        check("rst_period",    bus.period,    32'd0);
        check("rst_direction", {31'd0, bus.direction}, 32'd0);
        check("rst_moving",    {31'd0, bus.moving},    32'd0);
        check("rst_dir_error", {31'd0, bus.dir_error}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        mon_on = 1'b1;

        // First increment lands exactly 4 edges after the first high sample.
        push_step(1'b1);
        bus.step_in = 1'b1;
        repeat (4) @(negedge clk);
        check("latency_before", bus.position, 32'd0);
        @(negedge clk);
        check("latency_after", bus.position, 32'd1);
        bus.step_in = 1'b0;
        repeat (6) @(negedge clk);
        clear_pos("clear_no_edge");

        for (int i = 0; i < 5; i++) begin
            bus.enable = vecs[i].en;
            bus.dir_in = vecs[i].dir;
            repeat (8) @(negedge clk);
            for (int p = 0; p < vecs[i].n; p++) begin
                if (vecs[i].en) push_step(vecs[i].dir);
                pulse(vecs[i].hi, vecs[i].lo);
            end
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_position", i), bus.position, vecs[i].exp_pos);
            check($sformatf("v%0d_period", i), bus.period, vecs[i].exp_period);
            check($sformatf("v%0d_moving", i), {31'd0, bus.moving}, {31'd0, vecs[i].exp_mov});
            check($sformatf("v%0d_direction", i), {31'd0, bus.direction}, {31'd0, vecs[i].exp_dirn});
            check($sformatf("v%0d_dir_error", i), {31'd0, bus.dir_error}, 32'd0);
            check($sformatf("v%0d_drained", i), 32'(exp_q.size()), 32'd0);
        end

        // Single-cycle glitches are rejected; a 3-cycle pulse counts.
        for (int g = 0; g < 3; g++) pulse(1, 5);
        check("glitch_hold", bus.position, 32'd14);
        push_step(1'b1);
        pulse(3, 6);
        wait_pos(32'd15, "pulse3_counts");

        clear_pos("clear_for_down");
        bus.dir_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            push_step(1'b0);
            pulse(4, 4);
        end
        repeat (4) @(negedge clk);
        check("down_minus3", bus.position, 32'hFFFF_FFFD);

        mon_on = 1'b0;
        force dut.r_position = 32'sh7FFF_FFFF;
        @(negedge clk);
        release dut.r_position;
        bus.dir_in = 1'b1;
        @(negedge clk);
        check("preload", bus.position, 32'h7FFF_FFFF);
        tb_pos = 32'h7FFF_FFFF;
        @(negedge clk);
        mon_on = 1'b1;
        repeat (8) @(negedge clk);
        push_step(1'b1);
        pulse(4, 4);
        wait_pos(32'h8000_0000, "wrap_up");
        bus.dir_in = 1'b0;
        repeat (8) @(negedge clk);
        push_step(1'b0);
        pulse(4, 4);
        wait_pos(32'h7FFF_FFFF, "wrap_down");

        // Dir flipped only 2 cycles ahead of the step: counted with new dir, flagged.
        bus.dir_in = 1'b1;
        repeat (8) @(negedge clk);
        bus.dir_in = 1'b0;
        repeat (2) @(negedge clk);
        push_step(1'b0);
        pulse(4, 4);
        repeat (4) @(negedge clk);
        check("setup2_dir_error", {31'd0, bus.dir_error}, 32'd1);
        check("setup2_direction", {31'd0, bus.direction}, 32'd0);
        bus.error_clear = 1'b1;
        @(negedge clk);
        bus.error_clear = 1'b0;
        check("error_cleared", {31'd0, bus.dir_error}, 32'd0);
        bus.dir_in = 1'b1;
        repeat (5) @(negedge clk);
        push_step(1'b1);
        pulse(4, 4);
        repeat (4) @(negedge clk);
        check("setup5_dir_error", {31'd0, bus.dir_error}, 32'd0);
        check("setup5_direction", {31'd0, bus.direction}, 32'd1);

        repeat (8) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            push_step(1'b1);
            pulse(10, 10);
        end
        push_step(1'b1);
        bus.step_in = 1'b1;
        wait_pos(tb_pos, "to_last_edge");
        bus.step_in = 1'b0;
        check("to_period20", bus.period, 32'd20);
        repeat (98) @(negedge clk);
        check("to_moving_held", {31'd0, bus.moving}, 32'd1);
        check("to_period_held", bus.period, 32'd20);
        @(negedge clk);
        check("to_moving_dropped", {31'd0, bus.moving}, 32'd0);
        check("to_period_zero", bus.period, 32'd0);
        push_step(1'b1);
        pulse(10, 10);
        check("single_edge_moving", {31'd0, bus.moving}, 32'd0);
        check("single_edge_period", bus.period, 32'd0);
        push_step(1'b1);
        pulse(10, 10);
        check("second_edge_period", bus.period, 32'd20);
        check("second_edge_moving", {31'd0, bus.moving}, 32'd1);

        // Clear in the same cycle as a counted up-step.
        mon_on = 1'b0;
        bus.step_in = 1'b1;
        repeat (4) @(negedge clk);
        bus.position_clear = 1'b1;
        @(negedge clk);
        bus.position_clear = 1'b0;
        check("clear_with_edge", bus.position, 32'd1);
        bus.step_in = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-pulse, step held high through release gives exactly one edge.
        bus.step_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_position",  bus.position, 32'd0);
        check("midrst_period",    bus.period,   32'd0);
        check("midrst_direction", {31'd0, bus.direction}, 32'd0);
        check("midrst_moving",    {31'd0, bus.moving},    32'd0);
        check("midrst_dir_error", {31'd0, bus.dir_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tb_pos = 32'd0;
        push_step(1'b1);
        mon_on = 1'b1;
        wait_pos(32'd1, "release_edge");
        repeat (10) @(negedge clk);
        check("release_single", bus.position, 32'd1);
        bus.step_in = 1'b0;
        repeat (4) @(negedge clk);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
